// File: rtl/shift_sequencer.sv
// Iterative 32-bit shifter (SLL/SRL/SRA/pass) that applies one log2 stage per clock
// (1, 2, 4, 8, 16) through a single shared stage, with valid/ready on both sides.
module shift_sequencer #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 5
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [WIDTH-1:0] in_shamt,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;

    localparam logic [2:0] LAST_STAGE = 3'(STAGES - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] data_q;
    logic [1:0]       op_q;
    logic [4:0]       shamt_q;
    logic [2:0]       k_q;

    logic             accept;
    logic             ovf;
    logic [WIDTH-1:0] fill_value;
    logic             stage_en;
    logic [WIDTH-1:0] stage_data;

    // One fixed-distance stage; the distance is chosen by the stage counter, not by shamt.
    function automatic logic [WIDTH-1:0] stage_shift(
        input logic [WIDTH-1:0] d,
        input logic [1:0]       op,
        input logic [2:0]       k
    );
        logic             fill;
        logic [WIDTH-1:0] left;
        logic [WIDTH-1:0] right;
        fill  = (op == OP_SRA) ? d[WIDTH-1] : 1'b0;
        left  = d;
        right = d;
        case (k)
            3'd0: begin
                left  = {d[WIDTH-2:0], 1'b0};
                right = {fill, d[WIDTH-1:1]};
            end
            3'd1: begin
                left  = {d[WIDTH-3:0], 2'b0};
                right = {{2{fill}}, d[WIDTH-1:2]};
            end
            3'd2: begin
                left  = {d[WIDTH-5:0], 4'b0};
                right = {{4{fill}}, d[WIDTH-1:4]};
            end
            3'd3: begin
                left  = {d[WIDTH-9:0], 8'b0};
                right = {{8{fill}}, d[WIDTH-1:8]};
            end
            3'd4: begin
                left  = {d[WIDTH-17:0], 16'b0};
                right = {{16{fill}}, d[WIDTH-1:16]};
            end
            default: begin
                left  = d;
                right = d;
            end
        endcase
        case (op)
            OP_SLL:  stage_shift = left;
            OP_SRL:  stage_shift = right;
            OP_SRA:  stage_shift = right;
            default: stage_shift = d;
        endcase
    endfunction

    assign accept     = in_valid & in_ready;
    assign ovf        = (|in_shamt[WIDTH-1:STAGES]) & (in_op != OP_PASS);
    assign fill_value = (in_op == OP_SRA) ? {WIDTH{in_data[WIDTH-1]}} : '0;

    always_comb begin
        stage_en = 1'b0;
        case (k_q)
            3'd0:    stage_en = shamt_q[0];
            3'd1:    stage_en = shamt_q[1];
            3'd2:    stage_en = shamt_q[2];
            3'd3:    stage_en = shamt_q[3];
            3'd4:    stage_en = shamt_q[4];
            default: stage_en = 1'b0;
        endcase
        stage_data = stage_shift(data_q, op_q, k_q);
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A fresh accept in DONE behaves exactly like one from IDLE (back-to-back issue).
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = ovf ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (k_q == LAST_STAGE) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (accept) begin
                    state_next = ovf ? DONE : SHIFT;
                end else if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
        out_valid = (state == DONE);
        busy      = (state == SHIFT) | (state == DONE);
        out_data  = data_q;
    end

    // Overshift bypasses the stages by loading the fill value directly.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            data_q  <= '0;
            op_q    <= OP_SLL;
            shamt_q <= '0;
            k_q     <= '0;
        end else if (accept) begin
            data_q  <= ovf ? fill_value : in_data;
            op_q    <= in_op;
            shamt_q <= in_shamt[STAGES-1:0];
            k_q     <= '0;
        end else if (state == SHIFT) begin
            if (stage_en) begin
                data_q <= stage_data;
            end
            k_q <= (k_q == LAST_STAGE) ? 3'd0 : k_q + 3'd1;
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed vector table, multi-cycle corner sequences and a randomized streaming
// run for shift_sequencer, all checked against expectations computed here.
module tb_shift_sequencer;

    localparam logic [1:0] SLL  = 2'b00;
    localparam logic [1:0] SRL  = 2'b01;
    localparam logic [1:0] SRA  = 2'b10;
    localparam logic [1:0] PASS = 2'b11;
    localparam int NUM_VECTORS = 15;
    localparam int NUM_RANDOM  = 3000;

    logic        clk = 1'b0;
    logic        rstb;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [31:0] in_shamt;
    logic [1:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic [31:0] data;
        logic [31:0] shamt;
        logic [1:0]  op;
        logic [31:0] expected;
        int          latency;
    } vector_t;

    vector_t vectors[NUM_VECTORS];

    shift_sequencer dut (
        .clk       (clk),
        .rstb      (rstb),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] shiftModel(input logic [31:0] d, input logic [31:0] s,
                                               input logic [1:0] op);
        if (op == PASS) return d;
        if (s >= 32) return (op == SRA) ? {32{d[31]}} : 32'h0;
        case (op)
            SLL:     return d << s[4:0];
            SRL:     return d >> s[4:0];
            default: return 32'($signed(d) >>> s[4:0]);
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] data,
                                 input logic [31:0] shamt, input logic [1:0] op);
        in_valid = valid;
        in_data  = data;
        in_shamt = shamt;
        in_op    = op;
    endtask

    // Called at a falling edge; returns at the falling edge right after the accept edge.
    task automatic issueOp(input logic [31:0] data, input logic [31:0] shamt, input logic [1:0] op);
        int guard = 0;
        applyStimulus(1'b1, data, shamt, op);
        #1;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (!in_ready) checkOutput("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Latency counts rising edges from the accept edge (inclusive) to out_valid.
    task automatic waitResult(input string name, input logic [31:0] expected, input int latency);
        int lat = 1;
        #1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            #1;
            lat++;
        end
        checkOutput({name, "_latency"}, 32'(lat), 32'(latency));
        checkOutput({name, "_data"}, out_data, expected);
    endtask

    task automatic releaseResult(input string name);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        checkOutput({name, "_valid_drop"}, 32'(out_valid), 32'd0);
        checkOutput({name, "_busy_drop"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [31:0] exp_q[$];
        logic [31:0] r_data;
        logic [31:0] r_shamt;
        logic [1:0]  r_op;
        logic [31:0] bp_hold;
        int          sent;
        int          received;
        int          cycles;
        bit          accepted;

        vectors[0]  = '{32'h00000001, 32'd31,        SLL,  32'h80000000, 6};
        vectors[1]  = '{32'h80000000, 32'd4,         SRA,  32'hF8000000, 6};
        vectors[2]  = '{32'h80000000, 32'd4,         SRL,  32'h08000000, 6};
        vectors[3]  = '{32'h80000000, 32'd4,         PASS, 32'h80000000, 6};
        vectors[4]  = '{32'hFFFFFFFF, 32'd32,        SLL,  32'h00000000, 1};
        vectors[5]  = '{32'h80000001, 32'h100,       SRA,  32'hFFFFFFFF, 1};
        vectors[6]  = '{32'h12345678, 32'd0,         SRL,  32'h12345678, 6};
        vectors[7]  = '{32'h7FFFFFFF, 32'd31,        SRA,  32'h00000000, 6};
        vectors[8]  = '{32'hFFFFFFFF, 32'h20,        SRL,  32'h00000000, 1};
        vectors[9]  = '{32'hDEADBEEF, 32'h40,        PASS, 32'hDEADBEEF, 6};
        vectors[10] = '{32'hA5A5A5A5, 32'd5,         SLL,  32'hB4B4B4A0, 6};
        vectors[11] = '{32'h80000000, 32'd31,        SRA,  32'hFFFFFFFF, 6};
        vectors[12] = '{32'h80000000, 32'd31,        SRL,  32'h00000001, 6};
        vectors[13] = '{32'h7FFFFFFF, 32'h80000000,  SRA,  32'h00000000, 1};
        vectors[14] = '{32'h0000FFFF, 32'd16,        SLL,  32'hFFFF0000, 6};

        rstb      = 1'b0;
        out_ready = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'h0, SLL);
        @(negedge clk);
        #1;
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_out_data", out_data, 32'h0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rstb = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NUM_VECTORS; i++) begin
            issueOp(vectors[i].data, vectors[i].shamt, vectors[i].op);
            waitResult($sformatf("vec%0d", i), vectors[i].expected, vectors[i].latency);
            checkOutput($sformatf("vec%0d_busy", i), 32'(busy), 32'd1);
            checkOutput($sformatf("vec%0d_in_ready_held", i), 32'(in_ready), 32'd0);
            releaseResult($sformatf("vec%0d", i));
        end

        // Backpressure: result must hold for 10 cycles, then a same-edge reissue.
        issueOp(32'h00000003, 32'd2, SLL);
        waitResult("bp_first", 32'h0000000C, 6);
        bp_hold = 32'h0000000C;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            checkOutput("bp_hold_data", out_data, bp_hold);
            checkOutput("bp_hold_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        applyStimulus(1'b1, 32'hF0000000, 32'd4, SRA);
        #1;
        checkOutput("bp_same_edge_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        #1;
        checkOutput("bp_reissue_valid_drop", 32'(out_valid), 32'd0);
        checkOutput("bp_reissue_busy", 32'(busy), 32'd1);
        waitResult("bp_second", 32'hFF000000, 6);

        // Back-to-back overshift keeps out_valid high with the new result.
        out_ready = 1'b1;
        applyStimulus(1'b1, 32'h12345678, 32'd64, SLL);
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        #1;
        checkOutput("b2b_ovf_valid", 32'(out_valid), 32'd1);
        checkOutput("b2b_ovf_data", out_data, 32'h0);
        releaseResult("b2b_ovf");

        // Asynchronous reset in the middle of SHIFT (k=2).
        issueOp(32'hF0F0F0F0, 32'd3, SLL);
        @(negedge clk);
        @(negedge clk);
        rstb = 1'b0;
        #1;
        checkOutput("midreset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        checkOutput("midreset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("midreset_out_data", out_data, 32'h0);
        @(negedge clk);
        rstb = 1'b1;
        @(negedge clk);
        issueOp(32'hF0000000, 32'd8, SRL);
        waitResult("post_reset", 32'h00F00000, 6);
        releaseResult("post_reset");

        // Random streaming with gaps on both handshakes, scoreboarded in order.
        sent     = 0;
        received = 0;
        cycles   = 0;
        accepted = 1'b0;
        in_valid = 1'b0;
        while ((sent < NUM_RANDOM || exp_q.size() > 0) && cycles < 60000) begin
            @(negedge clk);
            if (accepted) in_valid = 1'b0;
            accepted = 1'b0;
            if (!in_valid && sent < NUM_RANDOM && $urandom_range(0, 3) != 0) begin
                r_data = $urandom();
                r_op   = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 7) == 0) r_shamt = $urandom() | 32'h00000020;
                else r_shamt = 32'($urandom_range(0, 31));
                applyStimulus(1'b1, r_data, r_shamt, r_op);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("[TB] FAIL rand_extra_result: got 0x%08h, expected no result", out_data);
                end else begin
                    checkOutput("rand_result", out_data, exp_q.pop_front());
                    received++;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(shiftModel(in_data, in_shamt, in_op));
                sent++;
                accepted = 1'b1;
            end
            @(posedge clk);
            cycles++;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checkOutput("rand_sent_count", 32'(sent), 32'(NUM_RANDOM));
        checkOutput("rand_received_count", 32'(received), 32'(NUM_RANDOM));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
